// File: rtl/mmio_uart_gpio.sv
// IO-page peripheral: LED/GPIO output register plus a full-duplex 8N1 UART with
// TX/RX FIFOs, sticky error flags and a registered RX-available interrupt.
module mmio_uart_gpio #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 115200,
    parameter int LED_W    = 6,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [3:0]       wordaddr,
    input  logic [3:0]       wmask,
    input  logic [31:0]      wdata,
    input  logic             ren,
    output logic [31:0]      rdata,
    output logic [LED_W-1:0] leds,
    input  logic             rxd,
    output logic             txd,
    output logic             irq
);
    localparam int CPB   = CLK_FREQ / BAUD;
    localparam int CNT_W = $clog2(CPB) + 1;
    localparam int TXA   = $clog2(TX_DEPTH);
    localparam int RXA   = $clog2(RX_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [TXA:0]     TX_PTR_ONE = {{TXA{1'b0}}, 1'b1};
    localparam logic [RXA:0]     RX_PTR_ONE = {{RXA{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} uart_state_e;

    logic             wr, rd, tx_wr, ctrl_wr, rx_pop, unused_wdata;
    logic [31:0]      status, rxdat;
    logic [LED_W-1:0] leds_d, leds_q;
    logic [7:0]       tx_mem_d [TX_DEPTH];
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [TXA:0]     tx_wp_d, tx_wp_q, tx_rp_d, tx_rp_q;
    logic             tx_full, tx_empty, tx_push, tx_pop, tx_busy;
    logic [7:0]       tx_head, tx_shift_d, tx_shift_q;
    uart_state_e      tx_state_d, tx_state_q, rx_state_d, rx_state_q;
    logic [CNT_W-1:0] tx_cnt_d, tx_cnt_q, rx_cnt_d, rx_cnt_q;
    logic [2:0]       tx_bit_d, tx_bit_q, rx_bit_d, rx_bit_q;
    logic             txd_d, txd_q;
    logic             rx_meta_d, rx_meta_q, rx_sync_d, rx_sync_q, rx_break_d, rx_break_q;
    logic [7:0]       rx_shift_d, rx_shift_q, rx_head;
    logic [7:0]       rx_mem_d [RX_DEPTH];
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [RXA:0]     rx_wp_d, rx_wp_q, rx_rp_d, rx_rp_q;
    logic             rx_full, rx_valid, rx_done, rx_push, frm_set;
    logic             rx_ovf_d, rx_ovf_q, tx_ovf_d, tx_ovf_q, frm_err_d, frm_err_q;
    logic             irq_en_d, irq_en_q, irq_d, irq_q;

    assign unused_wdata = ^wdata[31:9];

    // Bus decode, FIFO flags and the OR-combined read mux
    always_comb begin
        wr       = sel & (|wmask);
        rd       = sel & ren;
        tx_wr    = wr & wordaddr[1];
        ctrl_wr  = wr & wordaddr[2];
        tx_empty = (tx_wp_q == tx_rp_q);
        tx_full  = (tx_wp_q[TXA] != tx_rp_q[TXA]) && (tx_wp_q[TXA-1:0] == tx_rp_q[TXA-1:0]);
        tx_head  = tx_mem_q[tx_rp_q[TXA-1:0]];
        tx_busy  = ~tx_empty | (tx_state_q != S_IDLE);
        rx_valid = (rx_wp_q != rx_rp_q);
        rx_full  = (rx_wp_q[RXA] != rx_rp_q[RXA]) && (rx_wp_q[RXA-1:0] == rx_rp_q[RXA-1:0]);
        rx_head  = rx_mem_q[rx_rp_q[RXA-1:0]];
        rx_pop   = rd & wordaddr[3] & rx_valid;
        // Bit 9 mirrors tx_full for firmware that polls it as "busy".
        status   = {22'd0, tx_full, irq_en_q, 1'b0, frm_err_q, tx_ovf_q, rx_ovf_q,
                    rx_valid, tx_busy, tx_empty, tx_full};
        rxdat    = rx_valid ? {23'd0, 1'b1, rx_head} : 32'd0;
        rdata    = sel ? (({32{wordaddr[0]}} & 32'(leds_q)) |
                          ({32{wordaddr[2]}} & status) |
                          ({32{wordaddr[3]}} & rxdat)) : 32'd0;
    end

    // TX serialiser: start, 8 data bits LSB first, stop; chains frames without idle
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_cnt_d = CNT_ZERO;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_bit_d   = 3'd0;
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = S_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
        case (tx_state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = tx_shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    // RX synchroniser and deserialiser; a framing error holds off until the line idles high
    always_comb begin
        rx_meta_d  = rxd;
        rx_sync_d  = rx_meta_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_break_d = rx_break_q;
        rx_done    = 1'b0;
        frm_set    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                rx_cnt_d = CNT_ZERO;
                if (rx_break_q) begin
                    rx_break_d = ~rx_sync_q;
                end else if (!rx_sync_q) begin
                    rx_state_d = S_START;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = S_IDLE;
                    if (rx_sync_q) begin
                        rx_done = 1'b1;
                    end else begin
                        frm_set    = 1'b1;
                        rx_break_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    // FIFO storage, pointers, sticky flags, LED register and interrupt
    always_comb begin
        tx_push  = tx_wr & (~tx_full | tx_pop);
        rx_push  = rx_done & ~rx_full;
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q[TXA-1:0]] = wdata[7:0];
        end else begin
            tx_mem_d = tx_mem_q;
        end
        if (rx_push) begin
            rx_mem_d[rx_wp_q[RXA-1:0]] = rx_shift_q;
        end else begin
            rx_mem_d = rx_mem_q;
        end
        tx_wp_d   = tx_push ? (tx_wp_q + TX_PTR_ONE) : tx_wp_q;
        tx_rp_d   = tx_pop  ? (tx_rp_q + TX_PTR_ONE) : tx_rp_q;
        rx_wp_d   = rx_push ? (rx_wp_q + RX_PTR_ONE) : rx_wp_q;
        rx_rp_d   = rx_pop  ? (rx_rp_q + RX_PTR_ONE) : rx_rp_q;
        // Clear first, then OR in the set event so a coincident set wins.
        rx_ovf_d  = (rx_ovf_q  & ~(ctrl_wr & wdata[4])) | (rx_done & rx_full);
        tx_ovf_d  = (tx_ovf_q  & ~(ctrl_wr & wdata[5])) | (tx_wr & ~tx_push);
        frm_err_d = (frm_err_q & ~(ctrl_wr & wdata[6])) | frm_set;
        irq_en_d  = ctrl_wr ? wdata[8] : irq_en_q;
        irq_d     = irq_en_q & rx_valid;
        leds_d    = (wr & wordaddr[0]) ? wdata[LED_W-1:0] : leds_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leds_q     <= {LED_W{1'b0}};
            tx_mem_q   <= '{default: 8'h00};
            rx_mem_q   <= '{default: 8'h00};
            tx_wp_q    <= {(TXA+1){1'b0}};
            tx_rp_q    <= {(TXA+1){1'b0}};
            rx_wp_q    <= {(RXA+1){1'b0}};
            rx_rp_q    <= {(RXA+1){1'b0}};
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= CNT_ZERO;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_break_q <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            frm_err_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            leds_q     <= leds_d;
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_break_q <= rx_break_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_ovf_q   <= tx_ovf_d;
            frm_err_q  <= frm_err_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
        end
    end

    assign leds = leds_q;
    assign txd  = txd_q;
    assign irq  = irq_q;
endmodule

// File: tb/tb_mmio_uart_gpio.sv
// Directed bench for mmio_uart_gpio at 4 clocks per bit: bus access, TX framing,
// RX reception, error flags and asynchronous reset, checked against scoreboard queues.
module tb_mmio_uart_gpio;
    localparam logic [3:0] A_LED = 4'b0001;
    localparam logic [3:0] A_TX  = 4'b0010;
    localparam logic [3:0] A_CS  = 4'b0100;
    localparam logic [3:0] A_RX  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  wordaddr = 4'd0;
    logic [3:0]  wmask = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic [5:0]  leds;
    logic        rxd = 1'b1;
    logic        txd;
    logic        irq;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    logic mon_en = 1'b0;
    logic [8:0] tx_got[$];
    int         tx_start[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    mmio_uart_gpio #(.CLK_FREQ(4), .BAUD(1), .LED_W(6), .TX_DEPTH(8), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .wordaddr(wordaddr), .wmask(wmask),
        .wdata(wdata), .ren(ren), .rdata(rdata), .leds(leds), .rxd(rxd), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    // Decodes txd frames (sampled at bit centres) into tx_got with their start cycle.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       st;
        int         t;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txd === 1'b0) begin
                t = cyc;
                repeat (2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = txd;
                end
                repeat (4) @(negedge clk);
                st = txd;
                @(negedge clk);
                tx_got.push_back({st, b});
                tx_start.push_back(t);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        sel = 1'b1; wordaddr = a; wmask = m; wdata = d; ren = 1'b0;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        sel = 1'b0; wordaddr = 4'd0; wmask = 4'd0; wdata = 32'd0; ren = 1'b0;
    endtask

    task automatic wr_one(input logic [3:0] a, input logic [31:0] d);
        drive_wr(a, d, 4'hF);
        bus_idle();
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        sel = 1'b1; ren = 1'b1; wordaddr = a; wmask = 4'd0;
        #1 chk(tag, rdata, exp);
        bus_idle();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxd = fr[i];
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k;
        k = 0;
        while (tx_got.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("tx_frame_count", tx_got.size(), n);
    endtask

    task automatic tx_compare(input string tag);
        logic [8:0] got;
        logic [7:0] exp;
        exp = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'h00;
        got = (tx_got.size() > 0) ? tx_got.pop_front() : 9'h000;
        chk(tag, {23'd0, got}, {23'd0, 1'b1, exp});
    endtask

    task automatic rx_compare(input string tag);
        logic [7:0] exp;
        exp = (rx_exp.size() > 0) ? rx_exp.pop_front() : 8'h00;
        rd_chk(tag, A_RX, {23'd0, 1'b1, exp});
    endtask

    initial begin
        int t0, s0, s1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_leds", 32'(leds), 32'h0);
        chk("reset_txd", 32'(txd), 32'h1);
        chk("reset_irq", 32'(irq), 32'h0);
        rd_chk("reset_status", A_CS, 32'h002);
        rd_chk("reset_rxdat", A_RX, 32'h0);

        // LED register and bus decode
        wr_one(A_LED, 32'h3F);
        chk("led_write", 32'(leds), 32'h3F);
        rd_chk("led_read", A_LED, 32'h3F);
        @(negedge clk);
        sel = 1'b0; wordaddr = A_LED; wmask = 4'hF; wdata = 32'h0A;
        bus_idle();
        chk("led_sel0_ignored", 32'(leds), 32'h3F);
        drive_wr(A_LED, 32'h0A, 4'h0);
        bus_idle();
        chk("led_wmask0_ignored", 32'(leds), 32'h3F);
        drive_wr(A_LED, 32'hFFFF_FF15, 4'h1);
        bus_idle();
        chk("led_partial_mask", 32'(leds), 32'h15);
        @(negedge clk);
        sel = 1'b0; ren = 1'b1; wordaddr = 4'hF;
        #1 chk("rdata_sel0", rdata, 32'h0);
        bus_idle();
        rd_chk("rdata_multi_or", A_LED | A_CS, 32'h17);
        rd_chk("txdat_read_zero", A_TX, 32'h0);

        // Back-to-back TX frames
        mon_en = 1'b1;
        tx_exp.push_back(8'h55);
        tx_exp.push_back(8'hA3);
        drive_wr(A_TX, 32'h55, 4'hF);
        t0 = cyc;
        drive_wr(A_TX, 32'hA3, 4'hF);
        bus_idle();
        wait_tx(2, 150);
        s0 = (tx_start.size() > 0) ? tx_start.pop_front() : -1;
        s1 = (tx_start.size() > 0) ? tx_start.pop_front() : -1;
        chk("tx_first_start_latency", s0 - t0, 32'd2);
        chk("tx_back_to_back_gap", s1 - s0, 32'd40);
        tx_compare("tx_byte_55");
        tx_compare("tx_byte_a3");
        rd_chk("tx_idle_status", A_CS, 32'h002);
        chk("tx_idle_txd", 32'(txd), 32'h1);

        // TX FIFO overflow: TX_DEPTH+2 writes, first TX_DEPTH+1 go out
        tx_start.delete();
        for (int i = 0; i < 10; i++) begin
            drive_wr(A_TX, 32'(8'h10 + i), 4'hF);
            if (i < 9) tx_exp.push_back(8'(8'h10 + i));
        end
        bus_idle();
        rd_chk("tx_full_status", A_CS, 32'h225);
        wait_tx(9, 500);
        for (int i = 0; i < 9; i++) tx_compare("tx_ovf_byte");
        repeat (4) @(negedge clk);
        chk("tx_ovf_no_extra_frame", tx_got.size(), 0);
        rd_chk("tx_ovf_sticky", A_CS, 32'h022);
        wr_one(A_CS, 32'h20);
        rd_chk("tx_ovf_cleared", A_CS, 32'h002);

        // RX single frame with interrupt
        wr_one(A_CS, 32'h100);
        rd_chk("irq_en_set", A_CS, 32'h102);
        rx_exp.push_back(8'hC4);
        send_rx(8'hC4, 1'b1);
        repeat (6) @(negedge clk);
        chk("rx_irq_high", 32'(irq), 32'h1);
        rd_chk("rx_valid_status", A_CS, 32'h10A);
        rx_compare("rx_byte_c4");
        repeat (3) @(negedge clk);
        chk("rx_irq_low", 32'(irq), 32'h0);
        rd_chk("rx_empty_status", A_CS, 32'h102);
        rd_chk("rx_empty_read", A_RX, 32'h0);

        // Glitch rejection
        @(negedge clk); rxd = 1'b0;
        @(negedge clk); rxd = 1'b1;
        repeat (60) @(negedge clk);
        rd_chk("rx_glitch_status", A_CS, 32'h102);
        chk("rx_glitch_irq", 32'(irq), 32'h0);

        // Framing error, then recovery with a good frame
        send_rx(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        rd_chk("rx_frm_err", A_CS, 32'h142);
        wr_one(A_CS, 32'h140);
        rd_chk("rx_frm_cleared", A_CS, 32'h102);
        rx_exp.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (6) @(negedge clk);
        rx_compare("rx_after_frm_err");

        // RX FIFO overflow: RX_DEPTH+1 frames unread
        for (int i = 0; i < 5; i++) begin
            if (i < 4) rx_exp.push_back(8'(8'h81 + 8'(i * 23)));
            send_rx(8'(8'h81 + 8'(i * 23)), 1'b1);
        end
        repeat (6) @(negedge clk);
        chk("rx_ovf_irq", 32'(irq), 32'h1);
        rd_chk("rx_ovf_status", A_CS, 32'h11A);
        for (int i = 0; i < 4; i++) rx_compare("rx_ovf_byte");
        rd_chk("rx_ovf_drained", A_RX, 32'h0);
        wr_one(A_CS, 32'h110);
        rd_chk("rx_ovf_cleared", A_CS, 32'h102);

        // Asynchronous reset in the middle of a TX frame
        mon_en = 1'b0;
        wr_one(A_TX, 32'h00);
        repeat (8) @(negedge clk);
        chk("tx_midframe_low", 32'(txd), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_txd_async", 32'(txd), 32'h1);
        chk("reset_leds_async", 32'(leds), 32'h0);
        chk("reset_irq_async", 32'(irq), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("reset_status_after", A_CS, 32'h002);
        repeat (50) @(negedge clk);
        chk("reset_txd_stays_high", 32'(txd), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
